reg_file_access_ctrl: RTL and testbench
=======================================

// Module: reg_file_access_ctrl
// PURPOSE
//  Initiator side of the register-slice bus: generates Load_addr_1/Load_addr_2/Save_reg/Save_value
//  for the array of 32-bit register slices and captures the shared Addr_1/Addr_2 read buses.
//  Accepts operand-fetch requests (rs1, rs2) and writeback requests (rd, value) on valid/ready
//  channels. Returns operands with a write-bypass so software never sees the one-cycle save delay.
//  Sits between decode/writeback logic and the register-slice array.
// PARAMETERS
//  NUM_REGS  32  register numbers 1..NUM_REGS-1 exist as slices; 0 is the hard-wired zero register
//  ZERO_REG  0   idle/no-op register number driven on Load_addr_*/Save_reg (matches no slice)
// PORTS
//  clk          in   1   clock; single clock domain
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   operand-fetch request valid
//  req_ready    out  1   controller can accept a request
//  req_rs1      in   32  source register number A
//  req_rs2      in   32  source register number B
//  op_valid     out  1   op_a/op_b valid
//  op_ready     in   1   consumer accepts operands
//  op_a         out  32  value of rs1
//  op_b         out  32  value of rs2
//  wb_valid     in   1   writeback request valid
//  wb_ready     out  1   always 1 out of reset (one write per cycle)
//  wb_reg       in   32  destination register number
//  wb_value     in   32  value to write
//  Load_addr_1  out  32  read-port-1 register number to slice array
//  Load_addr_2  out  32  read-port-2 register number to slice array
//  Save_reg     out  32  register number to save into
//  Save_value   out  32  value to save
//  Addr_1       in   32  read bus 1 from slice array (undriven when no slice matches)
//  Addr_2       in   32  read bus 2 from slice array
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state IDLE; op_valid=0, op_a=op_b=0; Load_addr_*=Save_reg=ZERO_REG;
//    Save_value=0; wb_ready=0 during reset cycle; any in-flight request or writeback dropped.
//  - FSM IDLE -> READ -> HOLD -> IDLE. req_ready=1 only in IDLE.
//    IDLE: req_valid&req_ready registers rs1/rs2 into Load_addr_1/2; next state READ.
//    READ: Load_addr_* held; Addr_* sampled at end of cycle into op_a/op_b; next HOLD.
//    HOLD: op_valid=1; op_a/op_b stable; on op_ready -> IDLE, Load_addr_* back to ZERO_REG.
//  - Latency: request accepted cycle N -> op_valid asserted cycle N+2. Throughput 1 per 3 cycles min.
//  - Writeback: wb_valid in cycle N registers Save_reg=wb_reg, Save_value=wb_value for cycle N+1
//    only; slice updates at end of N+1; cycle N+2 Save_reg=ZERO_REG unless new wb. Back-to-back allowed.
//  - wb_reg==ZERO_REG or wb_reg>=NUM_REGS: write dropped (Save_reg stays ZERO_REG); wb still accepted.
//  - Operand select per port, priority order, evaluated in READ:
//    1) rs==ZERO_REG or rs>=NUM_REGS -> 0 (bus undriven, never sampled);
//    2) Save_reg==rs (write on bus this cycle) -> Save_value (bypass);
//    3) else Addr_n.
//  - Writeback accepted during HOLD to rs1/rs2 does NOT modify held op_a/op_b (snapshot semantics).
//  - rs1==rs2 legal; both ports return identical value.
//  - rst asserted in any state returns to IDLE next cycle, regardless of op_ready/wb_valid.
// STRUCTURE
//  - Package reg_bus_pkg: REG_W=32, NUM_REGS, ZERO_REG, state enum {IDLE, READ, HOLD}.
//  - Sub-module reg_bus_operand_mux (rs, Save_reg, Save_value, Addr_n -> operand), instantiated
//    twice, purely combinational; FSM, request and writeback registers in top.
// TESTING
//  1 reset: rst for 2 cycles -> op_valid=0, Load_addr_1/2=Save_reg=0, Save_value=0, req_ready=1 after.
//  2 read: slice 5=0x1234, slice 7=0xBEEF; req rs1=5 rs2=7 at N -> op_valid N+2, op_a=0x1234, op_b=0xBEEF.
//  3 bypass: wb reg 5=0xCAFE at N, req rs1=5 at N -> READ at N+1 sees Save_reg=5 -> op_a=0xCAFE.
//  4 zero/out of range: req rs1=0 rs2=40 -> op_a=0, op_b=0; wb reg 0=0xFFFF -> Save_reg stays 0.
//  5 backpressure: op_ready=0 for 4 cycles plus wb reg 7=0x1 during HOLD -> op_b stays 0xBEEF,
//    req_ready=0 throughout; op_ready=1 -> IDLE next cycle; next read of 7 returns 0x1.
//  6 reset mid-op: rst in READ -> next cycle IDLE, op_valid=0, pending Save_reg cleared to 0.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-slice bus initiator.
//   REG_W     : data and register-number width
//   NUM_REGS  : slices exist for register numbers 1..NUM_REGS-1
//   ZERO_REG  : idle/no-op register number; matches no slice
//   state_e   : operand-fetch FSM states
//   is_slice(): true when a register number addresses a real slice
package reg_bus_pkg;

    localparam int unsigned REG_W    = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD
    } state_e;

    function automatic logic is_slice(input logic [REG_W-1:0] r);
        return (r != ZERO_REG) && (r < NUM_REGS);
    endfunction

endpackage

// File: rtl/reg_bus_operand_mux.sv
// Combinational operand selection for one read port.
//   rs_i         : requested source register number
//   save_reg_i   : register number currently being saved on the bus
//   save_value_i : value currently being saved
//   addr_i       : read bus from the slice array (undriven when nothing matches)
//   operand_o    : selected operand value
module reg_bus_operand_mux
    import reg_bus_pkg::*;
(
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] save_reg_i,
    input  logic [REG_W-1:0] save_value_i,
    input  logic [REG_W-1:0] addr_i,
    output logic [REG_W-1:0] operand_o
);

    always_comb begin
        if (!is_slice(rs_i)) begin
            // Zero or out-of-range: nothing drives the bus, so never look at it.
            operand_o = '0;
        end else if (save_reg_i == rs_i) begin
            // Slice only updates at the end of this cycle; forward the new value.
            operand_o = save_value_i;
        end else begin
            operand_o = addr_i;
        end
    end

endmodule

// File: rtl/reg_file_access_ctrl.sv
// Initiator side of the register-slice bus. Accepts operand-fetch requests
// (rs1/rs2) and writebacks (rd/value), drives the slice array address/save
// lines, and returns operands with write-bypass.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready/req_rs*   : operand-fetch request channel
//   op_valid/op_ready/op_a/op_b   : operand response channel
//   wb_valid/wb_ready/wb_reg/wb_value : writeback channel (one per cycle)
//   Load_addr_1/Load_addr_2       : read-port register numbers to slices
//   Save_reg/Save_value           : save port to slices
//   Addr_1/Addr_2                 : shared read buses from slices
module reg_file_access_ctrl
    import reg_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_reg,
    input  logic [31:0] wb_value,
    output logic [31:0] Load_addr_1,
    output logic [31:0] Load_addr_2,
    output logic [31:0] Save_reg,
    output logic [31:0] Save_value,
    input  logic [31:0] Addr_1,
    input  logic [31:0] Addr_2
);

    state_e            state_q, state_d;
    logic [REG_W-1:0]  load_addr_1_q, load_addr_1_d;
    logic [REG_W-1:0]  load_addr_2_q, load_addr_2_d;
    logic [REG_W-1:0]  save_reg_q, save_reg_d;
    logic [REG_W-1:0]  save_value_q, save_value_d;
    logic [REG_W-1:0]  op_a_q, op_a_d;
    logic [REG_W-1:0]  op_b_q, op_b_d;
    logic [REG_W-1:0]  mux_a, mux_b;

    reg_bus_operand_mux u_mux_a (
        .rs_i         (load_addr_1_q),
        .save_reg_i   (save_reg_q),
        .save_value_i (save_value_q),
        .addr_i       (Addr_1),
        .operand_o    (mux_a)
    );

    reg_bus_operand_mux u_mux_b (
        .rs_i         (load_addr_2_q),
        .save_reg_i   (save_reg_q),
        .save_value_i (save_value_q),
        .addr_i       (Addr_2),
        .operand_o    (mux_b)
    );

    assign req_ready   = (state_q == IDLE);
    assign op_valid    = (state_q == HOLD);
    // Low only while reset is being applied.
    assign wb_ready    = ~rst;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign Load_addr_1 = load_addr_1_q;
    assign Load_addr_2 = load_addr_2_q;
    assign Save_reg    = save_reg_q;
    assign Save_value  = save_value_q;

    always_comb begin
        state_d       = state_q;
        load_addr_1_d = load_addr_1_q;
        load_addr_2_d = load_addr_2_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    load_addr_1_d = req_rs1;
                    load_addr_2_d = req_rs2;
                    state_d       = READ;
                end
            end
            READ: begin
                // Snapshot here; later writebacks do not touch held operands.
                op_a_d  = mux_a;
                op_b_d  = mux_b;
                state_d = HOLD;
            end
            HOLD: begin
                if (op_ready) begin
                    load_addr_1_d = ZERO_REG;
                    load_addr_2_d = ZERO_REG;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Save lines carry a write for exactly one cycle, then fall back to idle.
        save_reg_d   = ZERO_REG;
        save_value_d = '0;
        if (wb_valid && wb_ready && is_slice(wb_reg)) begin
            save_reg_d   = wb_reg;
            save_value_d = wb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            load_addr_1_q <= ZERO_REG;
            load_addr_2_q <= ZERO_REG;
            save_reg_q    <= ZERO_REG;
            save_value_q  <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
        end else begin
            state_q       <= state_d;
            load_addr_1_q <= load_addr_1_d;
            load_addr_2_q <= load_addr_2_d;
            save_reg_q    <= save_reg_d;
            save_value_q  <= save_value_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
        end
    end

endmodule

// File: tb/tb_reg_file_access_ctrl.sv
// Bench for reg_file_access_ctrl with a behavioural register-slice array.
module tb_reg_file_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_rs1, req_rs2;
    logic        op_valid, op_ready;
    logic [31:0] op_a, op_b;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_reg, wb_value;
    logic [31:0] Load_addr_1, Load_addr_2, Save_reg, Save_value;
    logic [31:0] Addr_1, Addr_2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        wb_en;
        logic [31:0] wb_reg;
        logic [31:0] wb_val;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    reg_file_access_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_reg      (wb_reg),
        .wb_value    (wb_value),
        .Load_addr_1 (Load_addr_1),
        .Load_addr_2 (Load_addr_2),
        .Save_reg    (Save_reg),
        .Save_value  (Save_value),
        .Addr_1      (Addr_1),
        .Addr_2      (Addr_2)
    );

    // Slice array: slice i starts at 0x1000_0000|i; unmatched bus reads as junk.
    logic        slice_init;
    logic [31:0] slices[32];

    always @(posedge clk) begin
        if (slice_init) begin
            for (int i = 0; i < 32; i++) slices[i] <= 32'h1000_0000 | i;
        end else if (Save_reg != 0 && Save_reg < 32) begin
            slices[Save_reg[4:0]] <= Save_value;
        end
    end

    assign Addr_1 = (Load_addr_1 != 0 && Load_addr_1 < 32) ? slices[Load_addr_1[4:0]]
                                                           : 32'hDEAD_DEAD;
    assign Addr_2 = (Load_addr_2 != 0 && Load_addr_2 < 32) ? slices[Load_addr_2[4:0]]
                                                           : 32'hDEAD_DEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on every operand handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_op: got op_a=%h op_b=%h want none", op_a, op_b);
            end else begin
                e = exp_q.pop_front();
                check("op_a", op_a, e.a);
                check("op_b", op_b, e.b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_wb(input logic [31:0] r, input logic [31:0] v);
        logic [31:0] exp_r;
        exp_r    = (r == 0 || r >= 32) ? 32'd0 : r;
        wb_valid = 1'b1;
        wb_reg   = r;
        wb_value = v;
        @(negedge clk);
        check("wb_ready", 32'(wb_ready), 1);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(negedge clk);
        check("save_reg_n1", Save_reg, exp_r);
        if (exp_r != 0) check("save_value_n1", Save_value, v);
        @(posedge clk); #1;
        @(negedge clk);
        check("save_reg_n2", Save_reg, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input vec_t v);
        req_valid = 1'b1;
        req_rs1   = v.rs1;
        req_rs2   = v.rs2;
        wb_valid  = v.wb_en;
        wb_reg    = v.wb_reg;
        wb_value  = v.wb_val;
        exp_q.push_back('{v.exp_a, v.exp_b});
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wb_valid  = 1'b0;
        @(negedge clk);
        check("op_valid_read", 32'(op_valid), 0);
        check("load_addr_1", Load_addr_1, v.rs1);
        if (v.wb_en)
            check("save_reg_wb", Save_reg,
                  (v.wb_reg == 0 || v.wb_reg >= 32) ? 32'd0 : v.wb_reg);
        @(posedge clk); #1;
        @(negedge clk);
        check("op_valid_hold", 32'(op_valid), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst        = 1'b1;
        slice_init = 1'b1;
        req_valid  = 1'b0;
        req_rs1    = '0;
        req_rs2    = '0;
        op_ready   = 1'b1;
        wb_valid   = 1'b0;
        wb_reg     = '0;
        wb_value   = '0;

        vecs[0] = '{1'b0, 32'd0,  32'h0,    32'd5,  32'd7,  32'h1234,      32'hBEEF};
        vecs[1] = '{1'b1, 32'd5,  32'hCAFE, 32'd5,  32'd7,  32'hCAFE,      32'hBEEF};
        vecs[2] = '{1'b0, 32'd0,  32'h0,    32'd0,  32'd40, 32'h0,         32'h0};
        vecs[3] = '{1'b1, 32'd0,  32'hFFFF, 32'd0,  32'd5,  32'h0,         32'hCAFE};
        vecs[4] = '{1'b0, 32'd0,  32'h0,    32'd7,  32'd7,  32'hBEEF,      32'hBEEF};
        vecs[5] = '{1'b1, 32'd31, 32'h55,   32'd31, 32'd1,  32'h55,        32'h1000_0001};
        vecs[6] = '{1'b1, 32'd40, 32'h77,   32'd31, 32'd3,  32'h55,        32'h1000_0003};
        vecs[7] = '{1'b1, 32'd3,  32'h33,   32'd2,  32'd3,  32'h1000_0002, 32'h33};

        // Reset for two cycles.
        @(posedge clk); #1;
        slice_init = 1'b0;
        @(negedge clk);
        check("wb_ready_in_rst", 32'(wb_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_op_valid", 32'(op_valid), 0);
        check("rst_load_addr_1", Load_addr_1, 0);
        check("rst_load_addr_2", Load_addr_2, 0);
        check("rst_save_reg", Save_reg, 0);
        check("rst_save_value", Save_value, 0);
        check("rst_op_a", op_a, 0);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_wb_ready", 32'(wb_ready), 1);
        @(posedge clk); #1;

        do_wb(32'd5, 32'h1234);
        do_wb(32'd7, 32'hBEEF);
        do_wb(32'd0, 32'hFFFF);

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Backpressure with a writeback to rs2 landing while operands are held.
        op_ready  = 1'b0;
        req_valid = 1'b1;
        req_rs1   = 32'd5;
        req_rs2   = 32'd7;
        exp_q.push_back('{32'hCAFE, 32'hBEEF});
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        wb_valid = 1'b1;
        wb_reg   = 32'd7;
        wb_value = 32'h1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_op_valid", 32'(op_valid), 1);
            check("bp_req_ready", 32'(req_ready), 0);
            check("bp_op_b", op_b, 32'hBEEF);
            @(posedge clk); #1;
            wb_valid = 1'b0;
        end
        op_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_idle_req_ready", 32'(req_ready), 1);
        check("bp_idle_op_valid", 32'(op_valid), 0);
        @(posedge clk); #1;
        run_txn('{1'b0, 32'd0, 32'h0, 32'd7, 32'd0, 32'h1, 32'h0});

        // Reset in READ with a writeback pending: both must be dropped.
        req_valid = 1'b1;
        req_rs1   = 32'd5;
        req_rs2   = 32'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        wb_valid  = 1'b1;
        wb_reg    = 32'd9;
        wb_value  = 32'h99;
        @(negedge clk);
        check("mid_rst_wb_ready", 32'(wb_ready), 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        wb_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_req_ready", 32'(req_ready), 1);
        check("mid_rst_op_valid", 32'(op_valid), 0);
        check("mid_rst_save_reg", Save_reg, 0);
        check("mid_rst_save_value", Save_value, 0);
        check("mid_rst_load_addr_1", Load_addr_1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_op_valid2", 32'(op_valid), 0);
        @(posedge clk); #1;
        run_txn('{1'b0, 32'd0, 32'h0, 32'd9, 32'd5, 32'h1000_0009, 32'hCAFE});

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
